// File: rtl/rns_pkg.sv
// Shared RNS types and a helper that multiplies two residues modulo m.
package rns_pkg;

    localparam int RNS_W = 8;

    typedef logic [RNS_W-1:0] rns_residue_t;

    // The product is formed at double width, so operands may exceed m
    function automatic rns_residue_t mod_mulred(input rns_residue_t a,
                                                input rns_residue_t b,
                                                input rns_residue_t m);
        logic [2*RNS_W-1:0] prod;
        prod = {{RNS_W{1'b0}}, a} * {{RNS_W{1'b0}}, b};
        return rns_residue_t'(prod % {{RNS_W{1'b0}}, m});
    endfunction

endpackage

// File: rtl/mod_mul_reg.sv
// One registered modular multiply, p <= (a*b) mod M, advancing only when en is high.
module mod_mul_reg
    import rns_pkg::*;
#(
    parameter rns_residue_t M = 8'd1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  rns_residue_t a,
    input  rns_residue_t b,
    output rns_residue_t p
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p <= '0;
        end else if (en) begin
            p <= mod_mulred(a, b, M);
        end
    end

endmodule

// File: rtl/fast_bconv_pipe.sv
// Streaming Fast-BConv from basis {qi} to basis {bj}: three stages, one sample per cycle,
// with a per-sample tag and a bypass mode that forwards xj mod bj through the same pipeline.
module fast_bconv_pipe
    import rns_pkg::*;
#(
    parameter int           IN_BASIS_LEN  = 3,
    parameter int           OUT_BASIS_LEN = 2,
    parameter int           TAG_W         = 8,
    parameter rns_residue_t IN_BASIS  [IN_BASIS_LEN]  = '{8'd5, 8'd7, 8'd11},
    parameter rns_residue_t OUT_BASIS [OUT_BASIS_LEN] = '{8'd13, 8'd17},
    parameter rns_residue_t ZiLUT     [IN_BASIS_LEN]  = '{8'd3, 8'd6, 8'd6},
    parameter rns_residue_t YMODB     [OUT_BASIS_LEN][IN_BASIS_LEN] =
        '{'{8'd12, 8'd3, 8'd9}, '{8'd9, 8'd4, 8'd1}}
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic                                 in_bypass,
    input  logic [TAG_W-1:0]                     in_tag,
    input  rns_residue_t [IN_BASIS_LEN-1:0]      input_RNSint,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [TAG_W-1:0]                     out_tag,
    output rns_residue_t [OUT_BASIS_LEN-1:0]     output_RNSint
);

    localparam int SUM_W = RNS_W + $clog2(IN_BASIS_LEN);
    localparam bit BYPASS_OK = (IN_BASIS_LEN >= OUT_BASIS_LEN);

    function automatic bit moduli_nonzero();
        bit ok;
        ok = 1'b1;
        for (int i = 0; i < IN_BASIS_LEN; i++) if (IN_BASIS[i] == '0) ok = 1'b0;
        for (int j = 0; j < OUT_BASIS_LEN; j++) if (OUT_BASIS[j] == '0) ok = 1'b0;
        return ok;
    endfunction

    localparam bit MODULI_OK = moduli_nonzero();

    // Handshake: a transfer happens on any edge where valid && ready on that side. All stages
    // share one enable, so the pipeline moves as a whole unless the output is held.
    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    logic             s1_valid, s2_valid, s1_bypass, s2_bypass;
    logic [TAG_W-1:0] s1_tag, s2_tag;
    rns_residue_t     raw_in [OUT_BASIS_LEN];
    rns_residue_t     s1_raw [OUT_BASIS_LEN];
    rns_residue_t     s2_raw [OUT_BASIS_LEN];
    rns_residue_t     s1_a   [IN_BASIS_LEN];
    rns_residue_t     s2_p   [OUT_BASIS_LEN][IN_BASIS_LEN];
    logic [SUM_W-1:0] sum    [OUT_BASIS_LEN];
    rns_residue_t     c_next [OUT_BASIS_LEN];

    for (genvar j = 0; j < OUT_BASIS_LEN; j++) begin : g_raw
        if (j < IN_BASIS_LEN) begin : g_lane
            assign raw_in[j] = input_RNSint[j];
        end else begin : g_none
            assign raw_in[j] = '0;
        end
    end

    for (genvar i = 0; i < IN_BASIS_LEN; i++) begin : g_s1
        mod_mul_reg #(.M(IN_BASIS[i])) u_mul (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (en),
            .a     (input_RNSint[i]),
            .b     (ZiLUT[i]),
            .p     (s1_a[i])
        );
    end

    for (genvar j = 0; j < OUT_BASIS_LEN; j++) begin : g_s2_out
        for (genvar i = 0; i < IN_BASIS_LEN; i++) begin : g_s2_in
            mod_mul_reg #(.M(OUT_BASIS[j])) u_mul (
                .clk   (clk),
                .rst_n (rst_n),
                .en    (en),
                .a     (s1_a[i]),
                .b     (YMODB[j][i]),
                .p     (s2_p[j][i])
            );
        end
    end

    // Each term is already < bj, so SUM_W bits hold the whole sum before the final reduction
    always_comb begin
        for (int j = 0; j < OUT_BASIS_LEN; j++) begin
            sum[j] = '0;
            for (int i = 0; i < IN_BASIS_LEN; i++) begin
                sum[j] = sum[j] + SUM_W'(s2_p[j][i]);
            end
            c_next[j] = s2_bypass ? mod_mulred(s2_raw[j], rns_residue_t'(1), OUT_BASIS[j])
                                  : rns_residue_t'(sum[j] % SUM_W'(OUT_BASIS[j]));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
            s1_bypass <= 1'b0;
            s2_bypass <= 1'b0;
            s1_tag    <= '0;
            s2_tag    <= '0;
            out_tag   <= '0;
            for (int j = 0; j < OUT_BASIS_LEN; j++) begin
                s1_raw[j]        <= '0;
                s2_raw[j]        <= '0;
                output_RNSint[j] <= '0;
            end
        end else if (en) begin
            s1_valid  <= in_valid;
            s2_valid  <= s1_valid;
            out_valid <= s2_valid;
            s1_bypass <= in_bypass;
            s2_bypass <= s1_bypass;
            s1_tag    <= in_tag;
            s2_tag    <= s1_tag;
            out_tag   <= s2_tag;
            for (int j = 0; j < OUT_BASIS_LEN; j++) begin
                s1_raw[j]        <= raw_in[j];
                s2_raw[j]        <= s1_raw[j];
                output_RNSint[j] <= c_next[j];
            end
        end
    end

    always_ff @(posedge clk) begin
        assert (MODULI_OK) else $error("fast_bconv_pipe: a basis modulus is zero");
        if (rst_n && en && in_valid && in_bypass) begin
            assert (BYPASS_OK) else $error("fast_bconv_pipe: bypass needs IN_BASIS_LEN >= OUT_BASIS_LEN");
        end
    end

endmodule

// File: tb/tb_fast_bconv_pipe.sv
// Directed bench for fast_bconv_pipe on the {5,7,11} -> {13,17} demo bases.
module tb_fast_bconv_pipe;
    import rns_pkg::*;

    logic                    clk;
    logic                    rst_n;
    logic                    in_valid;
    logic                    in_ready;
    logic                    in_bypass;
    logic [7:0]              in_tag;
    rns_residue_t [2:0]      input_RNSint;
    logic                    out_valid;
    logic                    out_ready;
    logic [7:0]              out_tag;
    rns_residue_t [1:0]      output_RNSint;

    fast_bconv_pipe dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_bypass     (in_bypass),
        .in_tag        (in_tag),
        .input_RNSint  (input_RNSint),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_tag       (out_tag),
        .output_RNSint (output_RNSint)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          passed = 0;
    int          total  = 0;
    int          fails  = 0;
    int          pops   = 0;
    logic [23:0] exp_q[$];
    logic        held   = 1'b0;
    logic [23:0] held_val;

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string name);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    // Golden model with hand-derived constants: returns {c1, c0}
    function automatic logic [15:0] model(input logic byp, input int x0, input int x1, input int x2);
        int a0, a1, a2, c0, c1;
        if (byp) begin
            c0 = x0 % 13;
            c1 = x1 % 17;
        end else begin
            a0 = (x0 * 3) % 5;
            a1 = (x1 * 6) % 7;
            a2 = (x2 * 6) % 11;
            c0 = (a0 * 12 + a1 * 3 + a2 * 9) % 13;
            c1 = (a0 * 9 + a1 * 4 + a2) % 17;
        end
        return {c1[7:0], c0[7:0]};
    endfunction

    // One clock cycle: drive at edge+1, check handshake/scoreboard at edge+2, return at next edge+1
    task automatic cycle(input logic v, input logic byp, input logic [7:0] tag,
                         input logic [7:0] x0, input logic [7:0] x1, input logic [7:0] x2,
                         input logic ordy, output logic acc);
        in_valid     = v;
        in_bypass    = byp;
        in_tag       = tag;
        input_RNSint = {x2, x1, x0};
        out_ready    = ordy;
        #1;
        chk({31'b0, in_ready}, {31'b0, (!out_valid || out_ready)}, "in_ready_rule");
        if (held) chk({8'b0, out_tag, output_RNSint}, {8'b0, held_val}, "hold_stable");
        held     = out_valid && !out_ready;
        held_val = {out_tag, output_RNSint};
        if (out_valid && out_ready) begin
            pops++;
            chk({31'b0, exp_q.size() != 0}, 32'd1, "spurious_output");
            if (exp_q.size() != 0) chk({8'b0, out_tag, output_RNSint}, {8'b0, exp_q.pop_front()}, "scoreboard");
        end
        acc = in_valid && in_ready;
        if (acc) exp_q.push_back({tag, model(byp, int'(x0), int'(x1), int'(x2))});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic ordy);
        logic acc;
        cycle(1'b0, 1'b0, 8'h00, 8'd0, 8'd0, 8'd0, ordy, acc);
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) idle(1'b1);
        chk(32'(exp_q.size()), 32'd0, name);
    endtask

    initial begin
        logic       acc;
        int         pops_before;
        logic [7:0] x0, x1, x2;
        logic       byp;

        rst_n = 1'b0; in_valid = 1'b0; in_bypass = 1'b0; in_tag = '0;
        input_RNSint = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk({31'b0, out_valid}, 32'd0, "reset_out_valid");
        chk({24'b0, out_tag}, 32'd0, "reset_out_tag");
        chk({16'b0, output_RNSint}, 32'd0, "reset_output");
        chk({31'b0, in_ready}, 32'd1, "reset_in_ready");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // x=100 -> {0,2,1} -> {4,9}, visible on the third edge counting the accept edge
        cycle(1'b1, 1'b0, 8'h11, 8'd0, 8'd2, 8'd1, 1'b1, acc);
        chk({31'b0, acc}, 32'd1, "x100_accept");
        chk({31'b0, out_valid}, 32'd0, "x100_lat_e1");
        idle(1'b1);
        chk({31'b0, out_valid}, 32'd0, "x100_lat_e2");
        idle(1'b1);
        chk({31'b0, out_valid}, 32'd1, "x100_lat_e3");
        chk({8'b0, out_tag, output_RNSint}, {8'b0, 8'h11, 8'd9, 8'd4}, "x100_data");
        drain("x100_drain");

        // x=1, bypass {3,5,9} tag A5, x=0 back to back
        cycle(1'b1, 1'b0, 8'h01, 8'd1, 8'd1, 8'd1, 1'b1, acc);
        cycle(1'b1, 1'b1, 8'hA5, 8'd3, 8'd5, 8'd9, 1'b1, acc);
        cycle(1'b1, 1'b0, 8'h02, 8'd0, 8'd0, 8'd0, 1'b1, acc);
        chk({8'b0, out_valid, out_tag, output_RNSint[1][6:0], output_RNSint[0]},
            {8'b0, 1'b1, 8'h01, 7'd6, 8'd4}, "x1_data");
        idle(1'b1);
        chk({8'b0, out_valid, out_tag, output_RNSint[1][6:0], output_RNSint[0]},
            {8'b0, 1'b1, 8'hA5, 7'd5, 8'd3}, "bypass_data");
        idle(1'b1);
        chk({8'b0, out_valid, out_tag, output_RNSint[1][6:0], output_RNSint[0]},
            {8'b0, 1'b1, 8'h02, 7'd0, 8'd0}, "x0_data");
        drain("mix_drain");

        // 64 back-to-back random samples at full rate
        pops_before = pops;
        for (int t = 0; t < 64; t++) begin
            x0 = 8'($urandom_range(0, 255));
            x1 = 8'($urandom_range(0, 255));
            x2 = 8'($urandom_range(0, 255));
            cycle(1'b1, 1'b0, 8'(t), x0, x1, x2, 1'b1, acc);
            chk({31'b0, acc}, 32'd1, "stream_in_ready");
        end
        drain("stream_drain");
        chk(32'(pops - pops_before), 32'd64, "stream_count");

        // Random backpressure with mixed bypass samples
        pops_before = pops;
        for (int s = 0; s < 40; s++) begin
            x0  = 8'($urandom_range(0, 255));
            x1  = 8'($urandom_range(0, 255));
            x2  = 8'($urandom_range(0, 255));
            byp = 1'($urandom_range(0, 1));
            acc = 1'b0;
            for (int tries = 0; tries < 30 && !acc; tries++)
                cycle(1'b1, byp, 8'(8'h40 + s), x0, x1, x2, 1'($urandom_range(0, 1)), acc);
            chk({31'b0, acc}, 32'd1, "bp_accept");
        end
        drain("bp_drain");
        chk(32'(pops - pops_before), 32'd40, "bp_count");

        // Reset with two samples in flight
        cycle(1'b1, 1'b0, 8'h70, 8'd1, 8'd1, 8'd1, 1'b1, acc);
        cycle(1'b1, 1'b0, 8'h71, 8'd0, 8'd2, 8'd1, 1'b1, acc);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk({31'b0, out_valid}, 32'd0, "flush_out_valid");
        chk({31'b0, in_ready}, 32'd1, "flush_in_ready");
        chk({8'b0, out_tag, output_RNSint}, 32'd0, "flush_output");
        exp_q.delete();
        held = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            idle(1'b1);
            chk({31'b0, out_valid}, 32'd0, "no_stale_output");
        end
        cycle(1'b1, 1'b0, 8'h77, 8'd0, 8'd2, 8'd1, 1'b1, acc);
        idle(1'b1);
        idle(1'b1);
        chk({8'b0, out_valid, out_tag, output_RNSint[1][6:0], output_RNSint[0]},
            {8'b0, 1'b1, 8'h77, 7'd9, 8'd4}, "post_reset_x100");
        drain("final_drain");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
